// File: rtl/core_scheduler.sv
// core_scheduler: per-core control FSM sitting directly behind the block
// dispatcher. Latches a block, then steps every enabled lane in lockstep
// through FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE until the block retires
// a RET, and reports done back to the dispatcher.
//
// Optional feature macro: CORE_SCHED_WATCHDOG_EN
//   defined   -> a WAIT watchdog aborts the block after WATCHDOG_CYCLES busy
//                WAIT cycles and raises timeout.
//   undefined -> no watchdog; timeout is tied low and WAIT waits forever.
//
// Handshake with the dispatcher: start is a level that is sampled only in
// IDLE; done is raised on DONE entry and held until start is seen low, at
// which point the core returns to IDLE. start changes outside IDLE/DONE are
// ignored.
module core_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8,
    parameter int WATCHDOG_CYCLES   = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [7:0]                   block_id,
    input  logic [7:0]                   thread_count,
    output logic                         fetch_req,
    output logic [PC_BITS-1:0]           fetch_addr,
    input  logic                         fetch_valid,
    input  logic                         decoded_ret,
    input  logic [THREADS_PER_BLOCK-1:0] lsu_busy,
    input  logic [PC_BITS-1:0]           next_pc,
    output logic [2:0]                   core_state,
    output logic [THREADS_PER_BLOCK-1:0] thread_enable,
    output logic [7:0]                   block_id_q,
    output logic [15:0]                  retired_count,
    output logic                         done,
    output logic                         timeout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REQUEST = 3'd3,
        S_WAIT    = 3'd4,
        S_EXECUTE = 3'd5,
        S_UPDATE  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t                       state;
    logic [PC_BITS-1:0]           pc;
    logic [THREADS_PER_BLOCK-1:0] lane_mask;
    logic                         lanes_busy;

    // The state register itself is the debug/broadcast view of the FSM.
    assign core_state = state;
    assign fetch_req  = (state == S_FETCH);
    assign fetch_addr = pc;

    // Only enabled lanes can hold the core in WAIT.
    assign lanes_busy = |(lsu_busy & thread_enable);

`ifdef CORE_SCHED_WATCHDOG_EN
    localparam int WD_RAW  = $clog2(WATCHDOG_CYCLES + 1);
    localparam int WD_BITS = (WD_RAW > 8) ? WD_RAW : 8;

    logic [WD_BITS-1:0] wd_cnt;
    logic               timeout_q;

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Lane i is enabled when i < min(thread_count, THREADS_PER_BLOCK).
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            lane_mask[i] = ({24'd0, thread_count} > 32'(i));
        end
    end

    // Control FSM with all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pc            <= '0;
            thread_enable <= '0;
            block_id_q    <= '0;
            retired_count <= '0;
            done          <= 1'b0;
`ifdef CORE_SCHED_WATCHDOG_EN
            wd_cnt        <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        block_id_q    <= block_id;
                        retired_count <= '0;
                        pc            <= '0;
                        thread_enable <= lane_mask;
`ifdef CORE_SCHED_WATCHDOG_EN
                        timeout_q     <= 1'b0;
`endif
                        // An empty block completes without fetching anything.
                        if (lane_mask == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (fetch_valid) begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state <= S_REQUEST;
                end
                S_REQUEST: begin
`ifdef CORE_SCHED_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!lanes_busy) begin
                        state <= S_EXECUTE;
`ifdef CORE_SCHED_WATCHDOG_EN
                    end else if (wd_cnt >= WD_BITS'(WATCHDOG_CYCLES - 1)) begin
                        // Abort without retiring the stalled instruction.
                        timeout_q <= 1'b1;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                S_EXECUTE: begin
                    state <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (retired_count != 16'hFFFF) begin
                        retired_count <= retired_count + 16'd1;
                    end
                    if (decoded_ret) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        pc    <= next_pc;
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        done          <= 1'b0;
                        thread_enable <= '0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/core_scheduler.md
Name: core_scheduler

Overview:
- Per-core control FSM; one instance per core, directly downstream of the block dispatcher.
- Consumes the dispatcher's per-core start, block ID and thread count. Steps all enabled threads of the block in lockstep: fetch, decode, request, wait, execute, update.
- Returns done to the dispatcher on RET.
- Single shared PC per block (no divergence). The PC/ALU/LSU datapath lives outside this block.

Parameters:
- THREADS_PER_BLOCK, 4, lanes per core; enable mask width.
- PC_BITS, 8, program counter width.
- WATCHDOG_CYCLES, 255, max WAIT cycles before timeout (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  core_start from dispatcher; level, held until done observed
- block_id  in  8  block index; latched on start
- thread_count  in  8  threads in this block; latched on start
- fetch_req  out  1  instruction fetch request
- fetch_addr  out  PC_BITS  fetch address (= current PC)
- fetch_valid  in  1  fetched instruction available this cycle
- decoded_ret  in  1  decoded instruction is RET; valid from EXECUTE onward
- lsu_busy  in  THREADS_PER_BLOCK  per-lane LSU outstanding
- next_pc  in  PC_BITS  PC for next instruction, from PC unit
- core_state  out  3  state encoding, broadcast to datapath
- thread_enable  out  THREADS_PER_BLOCK  active-lane mask
- block_id_q  out  8  latched block ID
- retired_count  out  16  instructions retired this block
- done  out  1  block complete (core_done to dispatcher)
- timeout  out  1  watchdog fired

Behaviour:
- Reset (any state, any cycle): state=IDLE; pc=0; thread_enable=0; block_id_q=0; retired_count=0; done=0; timeout=0. Outputs are registered except fetch_req and fetch_addr.
- State encoding: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
- IDLE: on start=1:
  - latch block_id, clear retired_count and timeout, set pc=0.
  - n = min(thread_count, THREADS_PER_BLOCK); thread_enable[i]=(i<n).
  - If n==0, go to DONE; else go to FETCH.
- FETCH:
  - fetch_req = 1 combinationally; fetch_addr = pc.
  - Stay until fetch_valid=1, then go to DECODE.
- DECODE, REQUEST: one cycle each.
  - REQUEST is the single-cycle LSU issue window, signalled via core_state.
- WAIT: leave when (lsu_busy & thread_enable)==0, evaluated every cycle including the first; then go to EXECUTE. Busy bits of disabled lanes are ignored.
- EXECUTE: one cycle.
- UPDATE:
  - retired_count += 1, saturating at 0xFFFF.
  - If decoded_ret, go to DONE (pc unchanged).
  - Else pc <= next_pc and go to FETCH. PC wraps naturally at 2^PC_BITS.
- Minimum latency is 6 cycles per instruction (FETCH through UPDATE) with fetch_valid and lsu idle immediate.
- DONE:
  - done=1, held while start=1.
  - When start=0: done<=0, thread_enable<=0, go to IDLE.
  - A new block may therefore start no earlier than two cycles after start drops.
- start deasserted mid-block (not DONE): ignored; the block runs to RET.
- start and reset together: reset wins.

Optional Feature:
- Macro: CORE_SCHED_WATCHDOG_EN.
- With the macro: an 8-bit+ counter clears on WAIT entry and increments each WAIT cycle. When it reaches WATCHDOG_CYCLES with lanes still busy, the block sets timeout=1, goes to DONE, and does not retire the instruction. timeout stays set until the next start latch or reset.
- Without the macro: no counter; timeout is tied to 0; WAIT waits indefinitely.

Test Plan:
- Reset, then start with thread_count=3, block_id=5. Fetch_valid and lsu idle immediate; decoded_ret asserted on the 2nd instruction, next_pc=1. -> thread_enable=0111, block_id_q=5, fetch_addr 0 then 1, done rises 12 cycles after FETCH entry, retired_count=2.
- Start with thread_count=9, THREADS_PER_BLOCK=4. -> thread_enable=1111. Start with thread_count=0 -> DONE next cycle, retired_count=0, fetch_req never asserted.
- Hold fetch_valid low 3 cycles, then lsu_busy=0010 for 4 WAIT cycles with enable=0011. -> FETCH lasts 4 cycles, WAIT lasts 5 cycles. Repeat with lsu_busy=1000 and enable=0011 -> WAIT lasts 1 cycle.
- In DONE, keep start high 5 cycles. -> done stays 1, then drop start -> done=0 the next cycle, state IDLE. Restart with block_id=7 -> retired_count cleared, block_id_q=7.
- Assert reset during WAIT with lsu_busy=1111. -> all outputs return to reset values next cycle; state IDLE.
- With CORE_SCHED_WATCHDOG_EN and WATCHDOG_CYCLES=10, hold lsu_busy=0001. -> timeout=1 and done=1 after 10 WAIT cycles, retired_count unchanged. Without the macro -> stuck in WAIT, timeout=0.
